// File: rtl/fcims_order_ctrl_if.sv
// Terminal-side request/acknowledge bundle for the food-court order scheduler.
// Terminals drive the master modport, the scheduler uses the slave modport.
interface fcims_order_ctrl_if #(
    parameter int N_REQ  = 4,
    parameter int ITEM_W = 2
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ITEM_W-1:0] req_item;
    logic [N_REQ*4-1:0]      req_qty;
    logic [N_REQ-1:0]        req_op;
    logic [N_REQ-1:0]        ack;
    logic                    ack_err;
    logic                    busy;

    modport master (output req, req_item, req_qty, req_op, input ack, ack_err, busy);
    modport slave  (input req, req_item, req_qty, req_op, output ack, ack_err, busy);
endinterface

// File: rtl/fcims_order_ctrl.sv
// Round-robin order scheduler sharing one price/stock/total engine between terminals.
// Optional macro FCIMS_SAT_EN: saturating total with sticky overflow flag.
module fcims_order_ctrl #(
    parameter int N_REQ  = 4,
    parameter int ITEM_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    fcims_order_ctrl_if.slave bus,
    input  logic              cfg_we,
    input  logic [ITEM_W-1:0] cfg_item,
    input  logic [3:0]        cfg_price,
    input  logic [3:0]        cfg_stock,
    input  logic              clr_total,
    input  logic [ITEM_W-1:0] rd_item,
    output logic [3:0]        rd_price,
    output logic [3:0]        rd_stock,
    output logic [7:0]        total_price,
    output logic              total_ovf
);
    localparam int N_ITEMS = 2**ITEM_W;
    localparam int IDX_W   = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_r;
    logic [IDX_W-1:0]  ptr_r;
    logic [IDX_W-1:0]  idx_r;
    logic [ITEM_W-1:0] item_r;
    logic [3:0]        qty_r;
    logic              op_r;
    logic [3:0]        price_cur_r;
    logic [3:0]        stock_cur_r;
    logic [3:0]        price_r [N_ITEMS];
    logic [3:0]        stock_r [N_ITEMS];
    logic [7:0]        total_r;
    logic [N_REQ-1:0]  ack_r;
    logic              ack_err_r;
    logic              busy_r;

    logic              grant_hit_s;
    logic [IDX_W-1:0]  grant_idx_s;
    logic [ITEM_W-1:0] item_arr_s [N_REQ];
    logic [3:0]        qty_arr_s  [N_REQ];
    logic [ITEM_W-1:0] sel_item_s;
    logic [3:0]        sel_qty_s;
    logic              sel_op_s;
    logic [4:0]        stock_sum_s;
    logic [7:0]        line_s;
    logic              exec_err_s;

    // Round-robin pick: scan from the pointer downward in priority so the nearest set bit wins last.
    always_comb begin
        int pos;
        grant_hit_s = 1'b0;
        grant_idx_s = '0;
        pos         = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos         = (int'(ptr_r) + k) % N_REQ;
            grant_idx_s = bus.req[IDX_W'(pos)] ? IDX_W'(pos) : grant_idx_s;
            grant_hit_s = grant_hit_s | bus.req[IDX_W'(pos)];
        end
    end

    // Unpack the winner's request fields.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            item_arr_s[k] = bus.req_item[k*ITEM_W +: ITEM_W];
            qty_arr_s[k]  = bus.req_qty[k*4 +: 4];
        end
        sel_item_s = item_arr_s[idx_r];
        sel_qty_s  = qty_arr_s[idx_r];
        sel_op_s   = bus.req_op[idx_r];
    end

    assign stock_sum_s = {1'b0, stock_cur_r} + {1'b0, qty_r};
    assign line_s      = {4'b0000, price_cur_r} * {4'b0000, qty_r};
    assign exec_err_s  = op_r ? stock_sum_s[4] : (qty_r > stock_cur_r);

`ifdef FCIMS_SAT_EN
    logic       ovf_r;
    logic [8:0] total_sum_s;
    assign total_sum_s = {1'b0, total_r} + {1'b0, line_s};
    assign total_ovf   = ovf_r;
`else
    assign total_ovf   = 1'b0;
`endif

    // Scheduler FSM, item tables and running total.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            idx_r       <= '0;
            item_r      <= '0;
            qty_r       <= 4'd0;
            op_r        <= 1'b0;
            price_cur_r <= 4'd0;
            stock_cur_r <= 4'd0;
            total_r     <= 8'd0;
            ack_r       <= '0;
            ack_err_r   <= 1'b0;
            busy_r      <= 1'b0;
            for (int i = 0; i < N_ITEMS; i++) begin
                price_r[i] <= 4'd0;
                stock_r[i] <= 4'd0;
            end
`ifdef FCIMS_SAT_EN
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cfg_we) begin
                        price_r[cfg_item] <= cfg_price;
                        stock_r[cfg_item] <= cfg_stock;
                    end else if (grant_hit_s) begin
                        idx_r   <= grant_idx_s;
                        busy_r  <= 1'b1;
                        state_r <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    item_r      <= sel_item_s;
                    qty_r       <= sel_qty_s;
                    op_r        <= sel_op_s;
                    price_cur_r <= price_r[sel_item_s];
                    stock_cur_r <= stock_r[sel_item_s];
                    state_r     <= ST_EXEC;
                end
                ST_EXEC: begin
                    // A rejected transaction leaves both tables and the total untouched.
                    if (!exec_err_s) begin
                        if (op_r) begin
                            stock_r[item_r] <= stock_sum_s[3:0];
                        end else begin
                            stock_r[item_r] <= stock_cur_r - qty_r;
`ifdef FCIMS_SAT_EN
                            if (total_sum_s[8]) begin
                                total_r <= 8'hFF;
                                ovf_r   <= 1'b1;
                            end else begin
                                total_r <= total_sum_s[7:0];
                            end
`else
                            total_r <= total_r + line_s;
`endif
                        end
                    end
                    ack_r     <= {{(N_REQ-1){1'b0}}, 1'b1} << idx_r;
                    ack_err_r <= exec_err_s;
                    state_r   <= ST_RESP;
                end
                ST_RESP: begin
                    ack_r     <= '0;
                    ack_err_r <= 1'b0;
                    busy_r    <= 1'b0;
                    ptr_r     <= (idx_r == IDX_W'(N_REQ - 1)) ? '0 : idx_r + IDX_W'(1);
                    state_r   <= ST_IDLE;
                end
                default: begin
                    ack_r     <= '0;
                    ack_err_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
            // Clearing the total overrides a commit landing on the same edge.
            if (clr_total) begin
                total_r <= 8'd0;
`ifdef FCIMS_SAT_EN
                ovf_r   <= 1'b0;
`endif
            end
        end
    end

    assign rd_price    = price_r[rd_item];
    assign rd_stock    = stock_r[rd_item];
    assign total_price = total_r;
    assign bus.ack     = ack_r;
    assign bus.ack_err = ack_err_r;
    assign bus.busy    = busy_r;
endmodule

// File: tb/tb_fcims_order_ctrl.sv
// Directed self-checking bench for fcims_order_ctrl (honours FCIMS_SAT_EN).
module tb_fcims_order_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [1:0] cfg_item;
    logic [3:0] cfg_price;
    logic [3:0] cfg_stock;
    logic       clr_total;
    logic [1:0] rd_item;
    logic [3:0] rd_price;
    logic [3:0] rd_stock;
    logic [7:0] total_price;
    logic       total_ovf;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    fcims_order_ctrl_if #(.N_REQ(4), .ITEM_W(2)) bus ();

    fcims_order_ctrl #(.N_REQ(4), .ITEM_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .cfg_we      (cfg_we),
        .cfg_item    (cfg_item),
        .cfg_price   (cfg_price),
        .cfg_stock   (cfg_stock),
        .clr_total   (clr_total),
        .rd_item     (rd_item),
        .rd_price    (rd_price),
        .rd_stock    (rd_stock),
        .total_price (total_price),
        .total_ovf   (total_ovf)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] item, input logic [3:0] price, input logic [3:0] stock);
        cfg_item  = item;
        cfg_price = price;
        cfg_stock = stock;
        cfg_we    = 1'b1;
        tick;
        cfg_we    = 1'b0;
    endtask

    // One transaction from an idle scheduler; optionally pulses clr_total into the EXEC cycle.
    task automatic txn(input int term, input logic [1:0] item, input logic [3:0] qty,
                       input logic op, input logic exp_err, input logic clr_exec);
        bus.req_item[term*2 +: 2] = item;
        bus.req_qty[term*4 +: 4]  = qty;
        bus.req_op[term]          = op;
        bus.req[term]             = 1'b1;
        tick;
        check("busy_grant", 32'(bus.busy), 32'd1);
        tick;
        check("ack_early", 32'(bus.ack), 32'd0);
        clr_total = clr_exec;
        tick;
        clr_total = 1'b0;
        check("ack_onehot", 32'(bus.ack), 32'd1 << term);
        check("ack_err", 32'(bus.ack_err), 32'(exp_err));
        bus.req[term] = 1'b0;
        tick;
        check("ack_drop", 32'(bus.ack), 32'd0);
        check("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        cfg_we       = 1'b0;
        cfg_item     = 2'd0;
        cfg_price    = 4'd0;
        cfg_stock    = 4'd0;
        clr_total    = 1'b0;
        rd_item      = 2'd1;
        bus.req      = 4'b0000;
        bus.req_item = 8'h00;
        bus.req_qty  = 16'h0000;
        bus.req_op   = 4'b0000;
        tick;
        tick;
        check("rst_total", 32'(total_price), 32'd0);
        check("rst_ovf", 32'(total_ovf), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_ack_err", 32'(bus.ack_err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_price", 32'(rd_price), 32'd0);
        check("rst_stock", 32'(rd_stock), 32'd0);
        reset = 1'b0;

        // Basic sell and rejected oversell
        cfg(2'd1, 4'd5, 4'd10);
        check("cfg_price", 32'(rd_price), 32'd5);
        check("cfg_stock", 32'(rd_stock), 32'd10);
        txn(0, 2'd1, 4'd3, 1'b0, 1'b0, 1'b0);
        check("sell_stock", 32'(rd_stock), 32'd7);
        check("sell_total", 32'(total_price), 32'd15);
        txn(1, 2'd1, 4'd9, 1'b0, 1'b1, 1'b0);
        check("oversell_stock", 32'(rd_stock), 32'd7);
        check("oversell_total", 32'(total_price), 32'd15);

        // Restock rejection, restock to full, zero quantity
        cfg(2'd2, 4'd3, 4'd8);
        rd_item = 2'd2;
        txn(2, 2'd2, 4'd10, 1'b1, 1'b1, 1'b0);
        check("rstk_err_stock", 32'(rd_stock), 32'd8);
        txn(3, 2'd2, 4'd7, 1'b1, 1'b0, 1'b0);
        check("rstk_stock", 32'(rd_stock), 32'd15);
        check("rstk_total", 32'(total_price), 32'd15);
        txn(1, 2'd2, 4'd0, 1'b0, 1'b0, 1'b0);
        check("qty0_stock", 32'(rd_stock), 32'd15);
        check("qty0_total", 32'(total_price), 32'd15);

        // Round robin with all requests held from pointer 0
        reset = 1'b1;
        tick;
        reset = 1'b0;
        cfg(2'd0, 4'd1, 4'd15);
        rd_item      = 2'd0;
        bus.req_item = 8'h00;
        bus.req_qty  = 16'h1111;
        bus.req_op   = 4'b0000;
        bus.req      = 4'b1111;
        for (int t = 1; t <= 19; t++) begin
            tick;
            check("rr_ack", 32'(bus.ack), ((t % 4) == 3) ? (32'd1 << (((t - 3) / 4) % 4)) : 32'd0);
        end
        bus.req = 4'b0000;
        tick;
        check("rr_stock", 32'(rd_stock), 32'd10);
        check("rr_total", 32'(total_price), 32'd5);

        // Total beyond 255
        clr_total = 1'b1;
        tick;
        clr_total = 1'b0;
        check("clr_idle", 32'(total_price), 32'd0);
        cfg(2'd3, 4'd15, 4'd15);
        rd_item = 2'd3;
        txn(0, 2'd3, 4'd15, 1'b0, 1'b0, 1'b0);
        check("big_total1", 32'(total_price), 32'd225);
        check("big_stock1", 32'(rd_stock), 32'd0);
        txn(1, 2'd3, 4'd15, 1'b1, 1'b0, 1'b0);
        check("big_rstk", 32'(rd_stock), 32'd15);
        txn(2, 2'd3, 4'd15, 1'b0, 1'b0, 1'b0);
`ifdef FCIMS_SAT_EN
        check("big_total2", 32'(total_price), 32'd255);
        check("big_ovf", 32'(total_ovf), 32'd1);
`else
        check("big_total2", 32'(total_price), 32'd194);
        check("big_ovf", 32'(total_ovf), 32'd0);
`endif

        // Clear coinciding with a sell commit
        txn(3, 2'd3, 4'd2, 1'b1, 1'b0, 1'b0);
        txn(0, 2'd3, 4'd1, 1'b0, 1'b0, 1'b1);
        check("clr_exec_total", 32'(total_price), 32'd0);
        check("clr_exec_ovf", 32'(total_ovf), 32'd0);
        check("clr_exec_stock", 32'(rd_stock), 32'd1);

        // Reset during GRANT aborts the transaction
        txn(1, 2'd3, 4'd0, 1'b1, 1'b0, 1'b0);
        bus.req_item[3:2] = 2'd3;
        bus.req_qty[7:4]  = 4'd1;
        bus.req_op[1]     = 1'b0;
        bus.req[1]        = 1'b1;
        tick;
        check("abort_busy", 32'(bus.busy), 32'd1);
        reset   = 1'b1;
        bus.req = 4'b0000;
        tick;
        reset = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick;
            check("abort_ack", 32'(bus.ack), 32'd0);
            check("abort_busy_low", 32'(bus.busy), 32'd0);
        end
        check("abort_stock", 32'(rd_stock), 32'd0);
        check("abort_price", 32'(rd_price), 32'd0);
        check("abort_total", 32'(total_price), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fcims_order_ctrl.md
Name: fcims_order_ctrl

Overview:
- Sequential order scheduler for the food-court inventory datapath.
- Shares one price/stock/total engine between N_REQ counter terminals using round-robin arbitration.
- Holds per-item unit price and stock count tables, executes one sell or restock transaction at a time, and accumulates the running total price.
- Sits above the count adder/subtracter, the 4x4 price multiplier and the 8-bit total adder, and sequences their use.

Parameters:
- N_REQ, 4, number of requesting terminals (2..8).
- ITEM_W, 2, item index width; N_ITEMS = 2**ITEM_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-terminal request; held high until that terminal's ack.
- req_item  in  N_REQ*ITEM_W  packed item index; terminal i uses slice i.
- req_qty  in  N_REQ*4  packed quantity, unsigned 0..15.
- req_op  in  N_REQ  0 = sell, 1 = restock.
- ack  out  N_REQ  one-hot completion strobe.
- ack_err  out  1  qualifies ack; 1 = rejected, no state changed.
- busy  out  1  high in GRANT, EXEC or RESP.
- cfg_we  in  1  configuration write strobe.
- cfg_item  in  ITEM_W  configuration target item.
- cfg_price  in  4  unit price to load.
- cfg_stock  in  4  stock count to load.
- clr_total  in  1  clear the running total.
- rd_item  in  ITEM_W  read-back select.
- rd_price  out  4  price[rd_item], combinational.
- rd_stock  out  4  stock[rd_item], combinational.
- total_price  out  8  running total.
- total_ovf  out  1  sticky overflow flag; constant 0 without the optional feature.

Behaviour:
- Reset (synchronous) forces:
  - state = IDLE, round-robin pointer = 0.
  - all price and stock entries = 0.
  - total_price = 0, total_ovf = 0.
  - ack = 0, ack_err = 0, busy = 0.
- FSM states: IDLE -> GRANT -> EXEC -> RESP -> IDLE. Every state lasts exactly 1 cycle except IDLE.
- IDLE:
  - If cfg_we = 1: write price[cfg_item] and stock[cfg_item]. Arbitration is deferred this cycle (configuration has priority).
  - Otherwise, if any req bit is set: pick the first set bit at or after the pointer, wrapping modulo N_REQ. Go to GRANT.
  - cfg_we is ignored in all other states.
- GRANT: latch the winner's index, item, qty and op. Read price[item] and stock[item].
- EXEC, sell:
  - If qty > stock: set err; no change.
  - Otherwise: stock -= qty; line = price*qty (8-bit, max 225); total += line, modulo 256.
- EXEC, restock:
  - If stock + qty > 15: set err; no change.
  - Otherwise: stock += qty. The total is not changed.
- qty = 0 completes without error and changes nothing.
- RESP:
  - ack[idx] = 1 and ack_err = err for this single cycle (Moore outputs of RESP).
  - Pointer <= idx+1 (wraps).
  - The terminal drops req on the same clock edge that ends RESP, so req is low in the following IDLE.
- Latency: req seen in IDLE at cycle 0 -> ack high in cycle 3. At most 1 transaction per 4 cycles.
- clr_total is accepted in any state. If it coincides with an EXEC commit, the clear wins (total = 0). It also clears total_ovf.
- req bits changing outside IDLE are ignored. The latched request is used.
- Reset asserted mid-transaction aborts it: no ack is issued, and tables return to reset values.

Optional Feature:
- FCIMS_SAT_EN defined:
  - Total saturates at 255 instead of wrapping.
  - total_ovf is set whenever a sell commit would exceed 255, and stays set until clr_total or reset.
- Not defined: total wraps modulo 256, and total_ovf is tied to 0.

Test Plan:
- Reset then cfg item1 = (price 5, stock 10); terminal 0 sells qty 3 on item1 -> ack[0] in cycle 3, ack_err = 0, stock[1] = 7, total = 15.
- Item1 stock 7; sell qty 9 -> ack_err = 1; stock stays 7; total unchanged.
- Restock qty 10 on an item with stock 8 -> ack_err = 1. Restock qty 7 -> stock = 15, total unchanged.
- req = 4'b1111 held, pointer 0 -> ack order 0, 1, 2, 3, 0; each ack 4 cycles apart.
- Price 15, stock 15; sell 15 twice after restocking (225 + 225):
  - Macro off -> total = 194 (450 mod 256), total_ovf = 0.
  - FCIMS_SAT_EN -> total = 255, total_ovf = 1.
- clr_total coincident with an EXEC sell -> total = 0. Reset asserted during GRANT -> no ack, state IDLE, all tables 0.
